// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_pkg : shared state encoding, counter sizing and exception constants  |
// | for the sequential divider (and its multiplier-side bench).              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CALC  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  localparam int   C_BIT_WIDTH_DEFAULT = 8;
  localparam logic C_DZ_QUOTIENT_BIT   = 1'b1;
  localparam logic C_OVF_RESULT_BIT    = 1'b0;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_step : one combinational restoring-division step.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_q_bit
);

  // Trial value is one bit wider than the divisor so the compare never wraps.
  logic [W:0] w_trial;

  assign w_trial = {i_rem, i_bit};
  assign o_q_bit = (w_trial >= {1'b0, i_divisor});
  assign o_rem   = o_q_bit ? W'(w_trial - {1'b0, i_divisor}) : w_trial[W-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider : multi-cycle restoring divider, 2W/W -> W quotient, W rem.  |
// | Define SIGNED_DIV_EN for two's-complement operands.                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_divider
  import div_pkg::*;
#(
  parameter int BIT_WIDTH = C_BIT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2*BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0]   divisor,
  output logic                   busy,
  output logic                   done,
  output logic [BIT_WIDTH-1:0]   quotient,
  output logic [BIT_WIDTH-1:0]   remainder,
  output logic                   div_by_zero,
  output logic                   overflow
);

  localparam int W     = BIT_WIDTH;
  localparam int CNT_W = cnt_width(BIT_WIDTH);

  div_state_e       r_state, w_state_nxt;
  logic [2*W-1:0]   r_num;
  logic [W-1:0]     r_den;
  logic [W-1:0]     r_den_mag;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic             r_ovf;

  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic             r_div_by_zero;
  logic             r_overflow;

  logic [2*W-1:0]   w_num_mag;
  logic [W-1:0]     w_den_mag;
  logic             w_dz;
  logic             w_ovf_mag;
  logic [W-1:0]     w_rem_nxt;
  logic             w_q_bit;
  logic [W-1:0]     w_q_fix;
  logic [W-1:0]     w_r_fix;
  logic             w_ovf_fix;
  logic             w_last_step;

`ifdef SIGNED_DIV_EN
  localparam logic [W-1:0] C_Q_MIN_MAG = {1'b1, {(W-1){1'b0}}};
  logic r_neg_q;
  logic r_neg_r;

  assign w_num_mag = r_num[2*W-1] ? -r_num : r_num;
  assign w_den_mag = r_den[W-1]   ? -r_den : r_den;
`else
  assign w_num_mag = r_num;
  assign w_den_mag = r_den;
`endif

  // A high half at or above the divisor would need more than W quotient bits.
  assign w_dz        = (r_den == '0);
  assign w_ovf_mag   = (w_num_mag[2*W-1:W] >= w_den_mag);
  assign w_last_step = (r_cnt == CNT_W'(W-1));

  div_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[W-1]),
    .i_divisor (r_den_mag),
    .o_rem     (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_state_nxt = CHECK;
      CHECK: begin
        busy = 1'b1;
        // Exceptions still pass through FIX so every result leaves via one path.
        w_state_nxt = (w_dz || w_ovf_mag) ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last_step) w_state_nxt = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_q_fix   = r_quo;
    w_r_fix   = r_rem;
    w_ovf_fix = r_ovf;
`ifdef SIGNED_DIV_EN
    if (r_neg_q) begin
      w_q_fix   = -r_quo;
      w_ovf_fix = r_ovf | (r_quo > C_Q_MIN_MAG);
    end else begin
      w_ovf_fix = r_ovf | r_quo[W-1];
    end
    if (r_neg_r) w_r_fix = -r_rem;
`endif
    if (r_dz) begin
      w_q_fix   = {W{C_DZ_QUOTIENT_BIT}};
      w_r_fix   = r_num[W-1:0];
      w_ovf_fix = 1'b0;
    end else if (w_ovf_fix) begin
      w_q_fix = {W{C_OVF_RESULT_BIT}};
      w_r_fix = {W{C_OVF_RESULT_BIT}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_num         <= '0;
      r_den         <= '0;
      r_den_mag     <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      r_ovf         <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_num <= dividend;
            r_den <= divisor;
          end
        end
        CHECK: begin
          r_rem     <= w_num_mag[2*W-1:W];
          r_quo     <= w_num_mag[W-1:0];
          r_den_mag <= w_den_mag;
          r_cnt     <= '0;
          r_dz      <= w_dz;
          r_ovf     <= !w_dz && w_ovf_mag;
`ifdef SIGNED_DIV_EN
          r_neg_q   <= r_num[2*W-1] ^ r_den[W-1];
          r_neg_r   <= r_num[2*W-1];
`endif
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[W-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_quotient    <= w_q_fix;
          r_remainder   <= w_r_fix;
          r_div_by_zero <= r_dz;
          r_overflow    <= w_ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_divider : directed and model-checked bench for seq_divider.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  quotient, remainder;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.BIT_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one op; returns at the negedge of the done cycle (or after the bound).
  task automatic run_op(input logic [15:0] n, input logic [7:0] d, output int lat);
    @(negedge clk);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~n;
    divisor  = ~d;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  // Reference model: {div_by_zero, overflow, quotient, remainder}
  function automatic logic [17:0] model(input logic [15:0] n, input logic [7:0] d);
    int ni, di, qi, ri;
    if (d == 8'd0) return {1'b1, 1'b0, 8'hFF, n[7:0]};
`ifdef SIGNED_DIV_EN
    ni = int'($signed(n));
    di = int'($signed(d));
    qi = ni / di;
    ri = ni % di;
    if (qi < -128 || qi > 127) return {1'b0, 1'b1, 16'h0000};
`else
    ni = int'(n);
    di = int'(d);
    if (n[15:8] >= d) return {1'b0, 1'b1, 16'h0000};
    qi = ni / di;
    ri = ni % di;
`endif
    return {1'b0, 1'b0, 8'(qi), 8'(ri)};
  endfunction

`ifdef SIGNED_DIV_EN
  localparam logic [15:0] N0 = 16'hFF9C;   // -100
  localparam logic [7:0]  D0 = 8'h07;
  localparam logic [7:0]  Q0 = 8'hF2;      // -14
  localparam logic [7:0]  R0 = 8'hFE;      // -2
`else
  localparam logic [15:0] N0 = 16'd1000;
  localparam logic [7:0]  D0 = 8'd7;
  localparam logic [7:0]  Q0 = 8'd142;
  localparam logic [7:0]  R0 = 8'd6;
`endif

  initial begin
    int          lat;
    int          ndone;
    int          qi, ri, ni, di;
    logic [15:0] n;
    logic [7:0]  d;
    logic [17:0] exp;

    // Reset state
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_outs", {14'd0, div_by_zero, overflow, quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main op and latency
    run_op(N0, D0, lat);
    chk("main_lat", lat, 32'd11);
    chk("main_q", {24'd0, quotient}, {24'd0, Q0});
    chk("main_r", {24'd0, remainder}, {24'd0, R0});
    chk("main_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    chk("main_busy_in_done", {31'd0, busy}, 32'd0);

    // Divide by zero: exception latency
    run_op(16'd500, 8'd0, lat);
    chk("dz_lat", lat, 32'd3);
    chk("dz_flags", {30'd0, div_by_zero, overflow}, 32'd2);
    chk("dz_q", {24'd0, quotient}, 32'hFF);
    chk("dz_r", {24'd0, remainder}, 32'hF4);

    // Overflow
    run_op(16'h1234, 8'h12, lat);
    chk("ovf_lat", lat, 32'd3);
    chk("ovf_flags", {30'd0, div_by_zero, overflow}, 32'd1);
    chk("ovf_qr", {16'd0, quotient, remainder}, 32'd0);

`ifdef SIGNED_DIV_EN
    run_op(16'd100, 8'hF9, lat);
    chk("s_pos_neg", {14'd0, div_by_zero, overflow, quotient, remainder}, {14'd0, 2'b00, 8'hF2, 8'h02});
    run_op(16'h8000, 8'hFF, lat);
    chk("s_min_m1", {30'd0, div_by_zero, overflow}, 32'd1);
    run_op(16'hFC00, 8'h08, lat);    // -1024/8 = -128, the most negative quotient
    chk("s_qmin", {14'd0, div_by_zero, overflow, quotient, remainder}, {14'd0, 2'b00, 8'h80, 8'h00});
    run_op(16'h0400, 8'h08, lat);    // +128 does not fit
    chk("s_qmax_ovf", {30'd0, div_by_zero, overflow}, 32'd1);
`else
    run_op(16'hFEFF, 8'hFF, lat);    // largest non-overflowing high half
    chk("u_edge", {14'd0, div_by_zero, overflow, quotient, remainder}, {14'd0, 2'b00, 8'hFF, 8'hFE});
`endif

    // Start while busy is ignored; exactly one done with first operands
    @(negedge clk);
    dividend = N0;
    divisor  = D0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    ndone = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) ndone++;
      if (done) begin
        chk("hs_lat", lat, 32'd11);
        chk("hs_qr", {16'd0, quotient, remainder}, {16'd0, Q0, R0});
      end
      if (lat == 1) chk("hs_busy", {31'd0, busy}, 32'd1);
      if (lat == 3 || lat == 7) begin
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("hs_ndone", ndone, 32'd1);

    // Async reset during the 4th CALC cycle
    run_op(16'd500, 8'd0, lat);      // leaves nonzero outputs behind
    @(negedge clk);
    dividend = N0;
    divisor  = D0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {12'd0, busy, done, div_by_zero, overflow, quotient, remainder}, 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_nodone", ndone, 32'd0);
    rst_n = 1'b1;
    run_op(N0, D0, lat);
    chk("rst_after_lat", lat, 32'd11);
    chk("rst_after_qr", {16'd0, quotient, remainder}, {16'd0, Q0, R0});

    // Random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      n = 16'($urandom_range(0, 65535));
      d = 8'($urandom_range(0, 255));
      if (i % 2 == 0) begin
`ifdef SIGNED_DIV_EN
        n = 16'($signed(8'($urandom_range(0, 255))) * $signed(d) + $signed(8'($urandom_range(0, 255))));
`else
        n[15:8] = 8'($urandom_range(0, (d > 0) ? int'(d) - 1 : 0));
`endif
      end
      exp = model(n, d);
      run_op(n, d, lat);
      chk("rnd_result", {14'd0, div_by_zero, overflow, quotient, remainder}, {14'd0, exp});
      if (!exp[17] && !exp[16]) begin
`ifdef SIGNED_DIV_EN
        qi = int'($signed(quotient));
        ri = int'($signed(remainder));
        ni = int'($signed(n));
        di = int'($signed(d));
`else
        qi = int'(quotient);
        ri = int'(remainder);
        ni = int'(n);
        di = int'(d);
`endif
        chk("rnd_identity", qi * di + ri, ni);
        chk("rnd_rem_small", {31'd0, ((ri < 0 ? -ri : ri) < (di < 0 ? -di : di))}, 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
